count_bcd_conv: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the parameterizable counter. It takes the counter's N-bit `count` value on a `start` request and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents D packed BCD digits, held stable, for the display or decode stage that follows.

---
 rtl/count_bcd_conv.sv | 120 ++++++++++++
 tb/tb_count_bcd_conv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module      : count_bcd_conv
//  Description : Sequential binary-to-BCD converter (shift-and-add-3).
//                Accepts an N-bit value on start, converts one bit per clock
//                and presents D packed BCD digits, held until the next
//                completion.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                start - conversion request, sampled only in IDLE
//                bin   - binary input, sampled on the accepting edge
//                busy  - high while shifting (N cycles)
//                done  - one-cycle pulse when bcd is updated
//                bcd   - packed BCD result, digit 0 in bits [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module count_bcd_conv #(
   parameter int N = 6,
   parameter int D = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   bin,
   output logic           busy,
   output logic           done,
   output logic [4*D-1:0] bcd
);

   localparam int CW = $clog2(N + 1);
   localparam int BW = 4 * D;

   // 10^D, saturating so very large D cannot wrap around.
   function automatic longint unsigned pow10(input int d);
      longint unsigned p;
      p = 64'd1;
      for (int k = 0; k < d; k++) begin
         if (p > 64'd1000000000000000000) return 64'hFFFF_FFFF_FFFF_FFFF;
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam longint unsigned MAX_BIN = (64'd1 << N) - 64'd1;

   // D digits must be able to hold the largest N-bit value.
   generate
      if (pow10(D) <= MAX_BIN) begin : g_bad_params
         $error("count_bcd_conv: D too small for N (need 10^D > 2^N-1)");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [N-1:0]    shreg;
   logic [BW-1:0]   scratch;
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   adj;
   logic [BW-1:0]   shifted;

   // Add-3 correction: each digit handled independently, no inter-digit carry.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < D; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   // Shift corrected scratch left, pulling in the next binary MSB.
   assign shifted = {adj[BW-2:0], shreg[N-1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= bin;
                  scratch <= '0;
                  cnt     <= CW'(N);
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               shreg   <= shreg << 1;
               scratch <= shifted;
               cnt     <= cnt - 1'b1;
               // Final iteration: publish the post-shift value on this edge.
               if (cnt == CW'(1)) begin
                  bcd   <= shifted;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_count_bcd_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_bcd_conv
//  Description : Scoreboard bench for count_bcd_conv. Two instances:
//                N=6/D=2 and N=8/D=3. Expected results come from a decimal
//                digit model; a monitor pops them on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_bcd_conv;

   typedef struct {
      int unsigned val;
      int unsigned acc;
   } exp_t;

   logic        clk;
   int unsigned cyc;

   logic        reset0, start0, busy0, done0;
   logic [5:0]  bin0;
   logic [7:0]  bcd0;
   logic        reset1, start1, busy1, done1;
   logic [7:0]  bin1;
   logic [11:0] bcd1;

   exp_t        q0[$];
   exp_t        q1[$];
   int          checks;
   int          failures;

   count_bcd_conv #(.N(6), .D(2)) u_dut6 (
      .clk(clk), .reset(reset0), .start(start0), .bin(bin0),
      .busy(busy0), .done(done0), .bcd(bcd0)
   );

   count_bcd_conv #(.N(8), .D(3)) u_dut8 (
      .clk(clk), .reset(reset1), .start(start1), .bin(bin1),
      .busy(busy1), .done(done1), .bcd(bcd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Decimal reference: pack the base-10 digits of v, least significant first.
   function automatic logic [11:0] ref_bcd(input int unsigned v);
      logic [11:0] r;
      int unsigned x;
      x = v;
      r = '0;
      for (int k = 0; k < 3; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input bit ok, input string name,
                        input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_in(input int idx, input logic s, input logic [7:0] b);
      if (idx == 0) begin
         start0 = s;
         bin0   = b[5:0];
      end else begin
         start1 = s;
         bin1   = b;
      end
   endtask

   // One conversion, starting from IDLE. Returns just after edge N+1, so the
   // next call is accepted at edge N+2.
   // mode 0: start low afterwards; 1: random start/bin noise;
   // 2: start held high; 3: start pulses with bin=12 in SHIFT and in DONE.
   task automatic conv(input int idx, input int unsigned v, input int mode);
      int   n;
      exp_t e;
      n = (idx == 0) ? 6 : 8;
      @(negedge clk);
      set_in(idx, 1'b1, 8'(v));
      @(posedge clk);
      #1;
      e.val = v;
      e.acc = cyc;
      if (idx == 0) q0.push_back(e); else q1.push_back(e);
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clk);
         case (mode)
            1:       set_in(idx, 1'($urandom), 8'($urandom));
            2:       set_in(idx, 1'b1, 8'($urandom));
            3:       set_in(idx, (k == 2) || (k == n + 1), 8'd12);
            default: set_in(idx, 1'b0, 8'($urandom));
         endcase
         @(posedge clk);
      end
   endtask

   task automatic idle(input int idx, input int k);
      for (int j = 0; j < k; j++) begin
         @(negedge clk);
         set_in(idx, 1'b0, 8'($urandom));
      end
   endtask

   // Per-instance monitor state.
   int          run [2];
   bit          pdone [2];
   logic [11:0] pbcd [2];

   task automatic monitor_one(input int idx);
      logic        r, b, d;
      logic [11:0] v;
      int          n;
      exp_t        e;
      bit          have;
      r = (idx == 0) ? reset0 : reset1;
      b = (idx == 0) ? busy0  : busy1;
      d = (idx == 0) ? done0  : done1;
      v = (idx == 0) ? {4'd0, bcd0} : bcd1;
      n = (idx == 0) ? 6 : 8;
      if (!r) begin
         check(!b && !d && v == 0, "reset_outputs", {b, d, v}, 0);
         run[idx]   = 0;
         pdone[idx] = 0;
         pbcd[idx]  = 0;
         return;
      end
      if (d) begin
         have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
         check(have, "unexpected_done", 1, 0);
         if (have) begin
            e = (idx == 0) ? q0.pop_front() : q1.pop_front();
            check(v == ref_bcd(e.val), "bcd_value", v, ref_bcd(e.val));
            check(cyc - e.acc == n, "latency", cyc - e.acc, n);
         end
         check(run[idx] == n, "busy_length", run[idx], n);
         check(!b, "busy_in_done", b, 0);
         check(!pdone[idx], "done_width", 2, 1);
      end else begin
         check(v == pbcd[idx], "bcd_stable", v, pbcd[idx]);
         if (b) run[idx]++;
         else run[idx] = 0;
      end
      pdone[idx] = d;
      pbcd[idx]  = v;
   endtask

   initial begin
      exp_t e;
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 2; i++) begin
         run[i]   = 0;
         pdone[i] = 0;
         pbcd[i]  = 0;
      end
      reset0 = 1'b0; start0 = 1'b0; bin0 = '0;
      reset1 = 1'b0; start1 = 1'b0; bin1 = '0;

      fork
         forever begin
            @(negedge clk);
            monitor_one(0);
            monitor_one(1);
         end
      join_none

      // Reset held for two cycles.
      repeat (2) @(negedge clk);
      check(!busy0 && !done0 && bcd0 == 8'h00, "reset_state6", {busy0, done0, bcd0}, 0);
      check(!busy1 && !done1 && bcd1 == 12'h000, "reset_state8", {busy1, done1, bcd1}, 0);
      reset0 = 1'b1;

      // Zero, counter max, full-scale.
      conv(0, 0, 0);
      idle(0, 2);
      conv(0, 20, 0);
      conv(0, 63, 0);
      idle(0, 1);

      // Full sweep with random noise and gaps.
      for (int v = 0; v < 64; v++) begin
         conv(0, v, int'($urandom_range(0, 2)));
         idle(0, int'($urandom_range(0, 2)));
      end

      // Start during SHIFT and DONE is ignored.
      conv(0, 45, 3);
      idle(0, 4);
      check(!busy0, "no_requeue", busy0, 0);

      // Reset mid-conversion after a 0x20 result.
      conv(0, 20, 0);
      idle(0, 2);
      @(negedge clk);
      set_in(0, 1'b1, 8'd37);
      @(posedge clk);
      #1;
      e.val = 37;
      e.acc = cyc;
      q0.push_back(e);
      set_in(0, 1'b0, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      reset0 = 1'b0;
      #1;
      check(bcd0 == 8'h00 && !busy0 && !done0, "midreset", {busy0, done0, bcd0}, 0);
      q0.delete();
      repeat (2) @(negedge clk);
      reset0 = 1'b1;
      conv(0, 37, 0);
      idle(0, 2);

      // Alternate parameters: N=8, D=3.
      reset1 = 1'b1;
      conv(1, 255, 0);
      idle(1, 2);
      for (int j = 0; j < 20; j++) conv(1, $urandom_range(0, 255), 2);
      for (int j = 0; j < 10; j++) conv(1, $urandom_range(0, 255), 1);
      idle(1, 3);

      repeat (3) @(negedge clk);
      check(q0.size() == 0, "pending6", q0.size(), 0);
      check(q1.size() == 0, "pending8", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
